// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM family.
// be_merge works on a fixed maximum width; callers widen and truncate.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    localparam int RDW_OLD    = 0;
    localparam int RDW_NEW    = 1;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: walks every address once in CLEAR, then parks in RUN.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 2**ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W:0] LAST_ADDR   = (ADDR_W+1)'(DEPTH - 1);
    localparam ram_state_t      RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    ram_state_t        state_r;
    ram_state_t        state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic              busy_r;

    // State, counter and busy flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RESET_STATE;
            cnt_r   <= '0;
            busy_r  <= CLEAR_ON_RESET;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == CLEAR);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            CLEAR: begin
                if ({1'b0, cnt_r} == LAST_ADDR) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = CLEAR;
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                end
            end
            RUN: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    assign init_busy = busy_r;
    assign clr_we    = busy_r;
    assign clr_addr  = cnt_r;

endmodule

// File: rtl/ram_sdp.sv
// Simple-dual-port RAM with byte-lane writes, registered read with valid/err,
// selectable read-during-write policy and a post-reset clear sequencer.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int RDW_MODE       = RDW_OLD,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_err
);

    localparam int              BE_W    = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable and never flags.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              rd_in_range_s;
    logic [DATA_W-1:0] rd_old_s;
    logic [DATA_W-1:0] rd_word_s;

    ram_init_seq #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s)
    );

    assign wr_ok_s       = wr_en && !init_busy && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok_s       = rd_en && !init_busy;
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
    assign rd_old_s      = mem_r[rd_addr];

    // Read word selection, including write-through forwarding when enabled
    always_comb begin
        rd_word_s = rd_old_s;
        if ((RDW_MODE == RDW_NEW) && wr_ok_s && (wr_addr == rd_addr)) begin
            rd_word_s = DATA_W'(be_merge(MAX_DATA_W'(rd_old_s),
                                         MAX_DATA_W'(wr_data),
                                         MAX_BE_W'(wr_be)));
        end else begin
            rd_word_s = rd_old_s;
        end
    end

    // Storage write port; the clear sequencer has priority over user writes
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s] <= '0;
        end else if (wr_ok_s) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) begin
                    mem_r[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Registered read port; data and err hold when no read is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_ok_s) begin
            rd_data  <= rd_in_range_s ? rd_word_s : '0;
            rd_valid <= 1'b1;
            rd_err   <= !rd_in_range_s;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Bench for ram_sdp: instance A uses defaults (8-bit, 256 words, old-data RDW),
// instance B is 32-bit, 200 words, write-through, checked against an array model.
module tb_ram_sdp;

    logic        clk;
    logic        rst;

    logic        a_busy, a_wr_en, a_rd_en, a_rd_valid, a_rd_err;
    logic [7:0]  a_wr_addr, a_wr_data, a_rd_addr, a_rd_data;
    logic [0:0]  a_wr_be;

    logic        b_busy, b_wr_en, b_rd_en, b_rd_valid, b_rd_err;
    logic [7:0]  b_wr_addr, b_rd_addr;
    logic [31:0] b_wr_data, b_rd_data;
    logic [3:0]  b_wr_be;

    int          n_vec;
    int          n_err;
    logic [31:0] bm [200];
    logic [31:0] m_data;
    logic        m_err;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic       rd_en;
        logic [7:0] rd_addr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [11];

    ram_sdp u_a (
        .clk (clk), .rst (rst), .init_busy (a_busy),
        .wr_en (a_wr_en), .wr_addr (a_wr_addr), .wr_data (a_wr_data), .wr_be (a_wr_be),
        .rd_en (a_rd_en), .rd_addr (a_rd_addr),
        .rd_data (a_rd_data), .rd_valid (a_rd_valid), .rd_err (a_rd_err)
    );

    ram_sdp #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk (clk), .rst (rst), .init_busy (b_busy),
        .wr_en (b_wr_en), .wr_addr (b_wr_addr), .wr_data (b_wr_data), .wr_be (b_wr_be),
        .rd_en (b_rd_en), .rd_addr (b_rd_addr),
        .rd_data (b_rd_data), .rd_valid (b_rd_valid), .rd_err (b_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs the clear phase from rst release, with reads/writes requested while busy.
    task automatic run_clear(output int ca, output int cb, output int vio);
        ca = 0; cb = 0; vio = 0;
        a_rd_en = 1'b1; a_rd_addr = 8'h55; a_wr_en = 1'b1; a_wr_addr = 8'h03; a_wr_data = 8'hFF;
        b_rd_en = 1'b1; b_rd_addr = 8'h00; b_wr_en = 1'b1; b_wr_addr = 8'h03; b_wr_data = 32'hFFFF_FFFF;
        b_wr_be = 4'hF;
        for (int i = 0; i < 400; i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            if ((a_busy && a_rd_valid) || (b_busy && b_rd_valid)) vio++;
            if (!a_busy) begin a_rd_en = 1'b0; a_wr_en = 1'b0; end
            if (!b_busy) begin b_rd_en = 1'b0; b_wr_en = 1'b0; end
            if (!a_busy && !b_busy) break;
            tick();
        end
    endtask

    // One cycle on instance B; returns the model's expected outputs and updates the model.
    task automatic b_cycle(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                           input logic [3:0] be, input logic re, input logic [7:0] ra,
                           output logic ev, output logic [31:0] ed, output logic ee);
        if (re) begin
            ev = 1'b1;
            if (ra >= 8'd200) begin
                ed = 32'h0;
                ee = 1'b1;
            end else begin
                ed = bm[ra];
                if (we && wa == ra) begin
                    for (int k = 0; k < 4; k++) if (be[k]) ed[8*k +: 8] = wd[8*k +: 8];
                end
                ee = 1'b0;
            end
            m_data = ed;
            m_err  = ee;
        end else begin
            ev = 1'b0;
            ed = m_data;
            ee = m_err;
        end
        if (we && wa < 8'd200) begin
            for (int k = 0; k < 4; k++) if (be[k]) bm[wa][8*k +: 8] = wd[8*k +: 8];
        end
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be;
        b_rd_en = re; b_rd_addr = ra;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    task automatic a_read(input logic [7:0] ra, input logic [7:0] exp, input string nm);
        a_rd_en = 1'b1; a_rd_addr = ra;
        tick();
        a_rd_en = 1'b0;
        chk({nm, "_valid"}, {31'd0, a_rd_valid}, 32'd1);
        chk({nm, "_data"}, {24'd0, a_rd_data}, {24'd0, exp});
    endtask

    initial begin
        int ca, cb, vio;
        logic ev, ee;
        logic [31:0] ed;
        logic we, re;
        logic [7:0] wa, ra;
        logic [31:0] wd;
        logic [3:0] be;

        n_vec = 0; n_err = 0; m_data = 32'h0; m_err = 1'b0;
        for (int i = 0; i < 200; i++) bm[i] = 32'h0;

        vecs[0]  = '{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'hA5, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b1, 8'h20, 8'h22, 1'b1, 8'h20, 1'b1, 8'h11, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b1, 8'h22, 1'b0};
        vecs[6]  = '{1'b1, 8'h30, 8'h33, 1'b1, 8'h10, 1'b1, 8'hA5, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 1'b1, 8'h33, 1'b0};
        vecs[8]  = '{1'b1, 8'hFF, 8'hEE, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hEE, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};

        rst = 1'b1;
        a_wr_en = 1'b0; a_wr_addr = 8'h0; a_wr_data = 8'h0; a_wr_be = 1'b1;
        a_rd_en = 1'b0; a_rd_addr = 8'h0;
        b_wr_en = 1'b0; b_wr_addr = 8'h0; b_wr_data = 32'h0; b_wr_be = 4'h0;
        b_rd_en = 1'b0; b_rd_addr = 8'h0;
        tick();
        tick();
        chk("rst_a_data",  {24'd0, a_rd_data}, 32'd0);
        chk("rst_a_valid", {31'd0, a_rd_valid}, 32'd0);
        chk("rst_a_err",   {31'd0, a_rd_err}, 32'd0);
        chk("rst_a_busy",  {31'd0, a_busy}, 32'd1);
        chk("rst_b_busy",  {31'd0, b_busy}, 32'd1);

        rst = 1'b0;
        run_clear(ca, cb, vio);
        chk("clear_cycles_a", ca, 32'd256);
        chk("clear_cycles_b", cb, 32'd200);
        chk("clear_rd_ignored", vio, 32'd0);

        a_read(8'h55, 8'h00, "post_clear_55");
        tick();
        chk("idle_valid_low", {31'd0, a_rd_valid}, 32'd0);
        a_read(8'h03, 8'h00, "clear_wr_ignored");
        b_cycle(1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 8'h03, ev, ed, ee);
        chk("b_clear_wr_ignored", b_rd_data, 32'h0);

        for (int i = 0; i < 11; i++) begin
            a_wr_en = vecs[i].wr_en; a_wr_addr = vecs[i].wr_addr; a_wr_data = vecs[i].wr_data;
            a_rd_en = vecs[i].rd_en; a_rd_addr = vecs[i].rd_addr;
            tick();
            chk($sformatf("vec%0d_valid", i), {31'd0, a_rd_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i),  {24'd0, a_rd_data},  {24'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_err", i),   {31'd0, a_rd_err},   {31'd0, vecs[i].exp_err});
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;

        b_cycle(1'b1, 8'd5, 32'h1122_3344, 4'hF, 1'b0, 8'd0, ev, ed, ee);
        b_cycle(1'b1, 8'd5, 32'hAABB_CCDD, 4'h5, 1'b0, 8'd0, ev, ed, ee);
        b_cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5, ev, ed, ee);
        chk("be_merge_read", b_rd_data, 32'h11BB_33DD);
        b_cycle(1'b1, 8'd7, 32'h11, 4'hF, 1'b0, 8'd0, ev, ed, ee);
        b_cycle(1'b1, 8'd7, 32'h22, 4'hF, 1'b1, 8'd7, ev, ed, ee);
        chk("rdw_new_full", b_rd_data, 32'h22);
        b_cycle(1'b1, 8'd8, 32'h1122_3344, 4'hF, 1'b0, 8'd0, ev, ed, ee);
        b_cycle(1'b1, 8'd8, 32'hAABB_CCDD, 4'h3, 1'b1, 8'd8, ev, ed, ee);
        chk("rdw_new_partial", b_rd_data, 32'h1122_CCDD);
        b_cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd8, ev, ed, ee);
        chk("rdw_new_after", b_rd_data, 32'h1122_CCDD);
        b_cycle(1'b1, 8'd250, 32'h77, 4'hF, 1'b0, 8'd0, ev, ed, ee);
        b_cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd250, ev, ed, ee);
        chk("oor_data",  b_rd_data, 32'h0);
        chk("oor_err",   {31'd0, b_rd_err}, 32'd1);
        chk("oor_valid", {31'd0, b_rd_valid}, 32'd1);
        b_cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0, ev, ed, ee);
        chk("oor_err_hold", {31'd0, b_rd_err}, 32'd1);
        chk("oor_valid_low", {31'd0, b_rd_valid}, 32'd0);
        b_cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd199, ev, ed, ee);
        chk("last_addr_err", {31'd0, b_rd_err}, 32'd0);
        chk("last_addr_data", b_rd_data, 32'h0);

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 8'($urandom_range(150, 255));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            re = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(150, 255));
            b_cycle(we, wa, wd, be, re, ra, ev, ed, ee);
            chk($sformatf("rnd%0d_valid", i), {31'd0, b_rd_valid}, {31'd0, ev});
            chk($sformatf("rnd%0d_data", i),  b_rd_data, ed);
            chk($sformatf("rnd%0d_err", i),   {31'd0, b_rd_err}, {31'd0, ee});
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("mid_clear_busy", {31'd0, a_busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, a_rd_valid}, 32'd0);
        rst = 1'b0;
        run_clear(ca, cb, vio);
        chk("reclear_cycles_a", ca, 32'd256);
        chk("reclear_cycles_b", cb, 32'd200);
        chk("reclear_rd_ignored", vio, 32'd0);
        a_read(8'h10, 8'h00, "reclear_10");
        a_read(8'hFF, 8'h00, "reclear_ff");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
